// File: rtl/signal_sync_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : signal_sync_bank_if
// Brief    : Pad-side inputs and synchronised level/valid/strobe outputs
// Revision : 1.0 - initial release
// ============================================================================
interface signal_sync_bank_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] signal_i;
  logic [WIDTH-1:0] signal_o;
  logic             valid_o;
  logic [WIDTH-1:0] edge_o;
  logic [WIDTH-1:0] posedge_o;
  logic [WIDTH-1:0] negedge_o;

  modport master (
    output signal_i,
    input  signal_o, valid_o, edge_o, posedge_o, negedge_o
  );

  modport slave (
    input  signal_i,
    output signal_o, valid_o, edge_o, posedge_o, negedge_o
  );
endinterface
`default_nettype wire

// File: rtl/signal_sync_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : signal_sync_bank
// Brief    : WIDTH-channel async-input synchroniser with glitch filter, level,
//            valid and one-cycle edge strobes
// Revision : 1.0 - initial release
// ============================================================================
module signal_sync_bank #(
  parameter int WIDTH         = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1
) (
  input  wire               clk_i,
  input  wire               rst_ni,
  signal_sync_bank_if.slave bus
);

  localparam int c_fill_w = $clog2(SYNC_STAGES + 1);
  localparam int c_cnt_w  = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
  logic [c_fill_w-1:0] r_fill;
  logic                r_valid;
  logic                w_fill_done;
  logic [WIDTH-1:0]    w_syn;
  logic [WIDTH-1:0]    w_level;
  logic [WIDTH-1:0]    w_edge;
  logic [WIDTH-1:0]    w_pos;
  logic [WIDTH-1:0]    w_neg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= bus.signal_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_syn       = r_sync[SYNC_STAGES-1];
  assign w_fill_done = (r_fill == c_fill_w'(SYNC_STAGES));

  // Shared fill tracking: valid only once the whole chain holds real samples
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (!w_fill_done) begin
        r_fill <= r_fill + c_fill_w'(1);
      end else begin
        r_valid <= 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_level;
      logic               r_edge;
      logic               r_pos;
      logic               r_neg;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_edge  <= 1'b0;
          r_pos   <= 1'b0;
          r_neg   <= 1'b0;
        end else begin
          r_edge <= 1'b0;
          r_pos  <= 1'b0;
          r_neg  <= 1'b0;
          if (!r_valid) begin
            // Initial load is silent: it reflects the first real sample, not a change
            r_cnt <= '0;
            if (w_fill_done) begin
              r_level <= w_syn[i];
            end
          end else if (w_syn[i] == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == c_cnt_w'(FILTER_CYCLES - 1)) begin
            r_level <= w_syn[i];
            r_cnt   <= '0;
            r_edge  <= 1'b1;
            r_pos   <= w_syn[i];
            r_neg   <= ~w_syn[i];
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
      end

      assign w_level[i] = r_level;
      assign w_edge[i]  = r_edge;
      assign w_pos[i]   = r_pos;
      assign w_neg[i]   = r_neg;
    end
  endgenerate

  assign bus.signal_o  = w_level;
  assign bus.valid_o   = r_valid;
  assign bus.edge_o    = w_edge;
  assign bus.posedge_o = w_pos;
  assign bus.negedge_o = w_neg;

endmodule
`default_nettype wire

// File: tb/tb_signal_sync_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_signal_sync_bank
// Brief    : Directed bench for three signal_sync_bank configurations
// Revision : 1.0 - initial release
// ============================================================================
module tb_signal_sync_bank;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [3:0]  a_in;
  logic [3:0]  a_prev;
  logic [15:0] b_in, b_lvl, b_pos, b_neg;
  logic [15:0] c_in, c_lvl, c_pos, c_neg;

  signal_sync_bank_if #(.WIDTH(4)) ifa ();
  signal_sync_bank_if #(.WIDTH(1)) ifb ();
  signal_sync_bank_if #(.WIDTH(1)) ifc ();

  signal_sync_bank #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1)) u_a (
    .clk_i (clk), .rst_ni (rst_n), .bus (ifa.slave)
  );
  signal_sync_bank #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_CYCLES(3)) u_b (
    .clk_i (clk), .rst_ni (rst_n), .bus (ifb.slave)
  );
  signal_sync_bank #(.WIDTH(1), .SYNC_STAGES(3), .FILTER_CYCLES(4)) u_c (
    .clk_i (clk), .rst_ni (rst_n), .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] lvl, input logic vld,
                       input logic [3:0] pos, input logic [3:0] neg);
    check({tag, ".sig"},   32'(ifa.signal_o),  32'(lvl));
    check({tag, ".valid"}, 32'(ifa.valid_o),   32'(vld));
    check({tag, ".pos"},   32'(ifa.posedge_o), 32'(pos));
    check({tag, ".neg"},   32'(ifa.negedge_o), 32'(neg));
    check({tag, ".edge"},  32'(ifa.edge_o),    32'(pos | neg));
  endtask

  initial begin
    // Channel pattern for a: ch1 and ch3 high, ch0 and ch2 low
    rst_n        = 1'b0;
    a_in         = 4'b1010;
    ifa.signal_i = a_in;
    ifb.signal_i = 1'b0;
    ifc.signal_i = 1'b0;

    tick();
    chk_a("rst_first", 4'h0, 1'b0, 4'h0, 4'h0);
    repeat (4) tick();
    chk_a("rst_held", 4'h0, 1'b0, 4'h0, 4'h0);
    check("rst_b_valid", 32'(ifb.valid_o), 32'd0);
    check("rst_c_sig",   32'(ifc.signal_o), 32'd0);

    rst_n = 1'b1;
    tick();
    chk_a("fill1", 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk_a("fill2", 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk_a("fill3", 4'b1010, 1'b1, 4'h0, 4'h0);
    check("fill3_b_valid", 32'(ifb.valid_o), 32'd1);
    check("fill3_c_valid", 32'(ifc.valid_o), 32'd0);
    tick();
    chk_a("fill4", 4'b1010, 1'b1, 4'h0, 4'h0);
    check("fill4_c_valid", 32'(ifc.valid_o), 32'd1);

    // Square wave on ch0: 5-cycle half period, update 2 cycles after capture
    for (int k = 0; k < 4; k++) begin
      a_prev       = a_in;
      a_in[0]      = ~a_in[0];
      ifa.signal_i = a_in;
      tick();
      tick();
      chk_a("sq_wait", a_prev, 1'b1, 4'h0, 4'h0);
      tick();
      chk_a("sq_upd", a_in, 1'b1, a_in[0] ? 4'b0001 : 4'b0000, a_in[0] ? 4'b0000 : 4'b0001);
      tick();
      chk_a("sq_after", a_in, 1'b1, 4'h0, 4'h0);
      tick();
    end

    // b (S=2,F=3): 2-cycle pulse rejected, 3-cycle pulse accepted
    b_in  = 16'h01C3;
    b_lvl = 16'h1C00;
    b_pos = 16'h0400;
    b_neg = 16'h2000;
    for (int k = 0; k < 16; k++) begin
      ifb.signal_i = b_in[k];
      tick();
      check("glitch_sig", 32'(ifb.signal_o),  32'(b_lvl[k]));
      check("glitch_pos", 32'(ifb.posedge_o), 32'(b_pos[k]));
      check("glitch_neg", 32'(ifb.negedge_o), 32'(b_neg[k]));
    end

    // c (S=3,F=4): high 3, low 1, high 4 -- only the second run counts
    c_in  = 16'h00F7;
    c_lvl = 16'h3C00;
    c_pos = 16'h0400;
    c_neg = 16'h4000;
    for (int k = 0; k < 16; k++) begin
      ifc.signal_i = c_in[k];
      tick();
      check("intr_sig",  32'(ifc.signal_o), 32'(c_lvl[k]));
      check("intr_pos",  32'(ifc.posedge_o), 32'(c_pos[k]));
      check("intr_neg",  32'(ifc.negedge_o), 32'(c_neg[k]));
      check("intr_edge", 32'(ifc.edge_o), 32'(c_pos[k] | c_neg[k]));
    end

    // Multi-channel: ch0/ch2 rise, ch1 falls, ch3 stays high
    a_in         = 4'b1101;
    ifa.signal_i = a_in;
    tick();
    tick();
    chk_a("multi_wait", 4'b1010, 1'b1, 4'h0, 4'h0);
    tick();
    chk_a("multi_upd", 4'b1101, 1'b1, 4'b0101, 4'b0010);
    tick();
    chk_a("multi_after", 4'b1101, 1'b1, 4'h0, 4'h0);

    // Mid-operation reset while c has a filter count running
    ifc.signal_i = 1'b1;
    repeat (4) tick();
    check("mid_pre_c_sig", 32'(ifc.signal_o), 32'd0);
    rst_n = 1'b0;
    tick();
    chk_a("midrst", 4'h0, 1'b0, 4'h0, 4'h0);
    check("midrst_c_sig",   32'(ifc.signal_o),  32'd0);
    check("midrst_c_valid", 32'(ifc.valid_o),   32'd0);
    check("midrst_c_pos",   32'(ifc.posedge_o), 32'd0);
    check("midrst_b_valid", 32'(ifb.valid_o),   32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk_a("refill2", 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk_a("refill3", 4'b1101, 1'b1, 4'h0, 4'h0);
    check("refill3_c_valid", 32'(ifc.valid_o), 32'd0);
    tick();
    check("refill4_c_valid", 32'(ifc.valid_o),   32'd1);
    check("refill4_c_sig",   32'(ifc.signal_o),  32'd1);
    check("refill4_c_pos",   32'(ifc.posedge_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
